// File: rtl/logic_op_sequencer.sv
// Logical/shift execution unit: bitwise ops finish in one registered cycle,
// shifts and rotates advance one bit position per cycle under a down-counter.
module logic_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] work_r;
  logic [CNT_W-1:0] count_r;
  logic [1:0]       sh_op_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             neg_r;

  logic [CNT_W-1:0] amt_s;
  logic             multi_s;
  logic [WIDTH-1:0] imm_s;
  logic [WIDTH-1:0] step_s;

  // One bit of movement for the latched shift kind (op[1:0] of a 1xx op).
  function automatic logic [WIDTH-1:0] shift_one(input logic [1:0] kind,
                                                 input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    case (kind)
      2'b00:   r = {v[WIDTH-2:0], 1'b0};
      2'b01:   r = {1'b0, v[WIDTH-1:1]};
      2'b10:   r = {v[WIDTH-2:0], v[WIDTH-1]};
      2'b11:   r = {v[0], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Single-cycle result; a zero-length shift simply passes a through.
  function automatic logic [WIDTH-1:0] single_cycle(input logic [2:0] o,
                                                    input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (o)
      3'b000:  r = ~x;
      3'b001:  r = x & y;
      3'b010:  r = x | y;
      3'b011:  r = x ^ y;
      default: r = x;
    endcase
    return r;
  endfunction

  assign amt_s   = b[CNT_W-1:0];
  assign multi_s = op[2] && (amt_s != {CNT_W{1'b0}});
  assign imm_s   = single_cycle(op, a, b);
  assign step_s  = shift_one(sh_op_r, work_r);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; start is only honoured outside SHIFT.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (multi_s) begin
            state_nxt_s = ST_SHIFT;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (count_r == CNT_ONE) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_r)
      ST_SHIFT: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Work register, counter and the held result/flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_r   <= {WIDTH{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      sh_op_r  <= 2'b00;
      result_r <= {WIDTH{1'b0}};
      zero_r   <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_SHIFT: begin
          work_r  <= step_s;
          count_r <= count_r - CNT_ONE;
          if (count_r == CNT_ONE) begin
            result_r <= step_s;
            zero_r   <= (step_s == {WIDTH{1'b0}});
            neg_r    <= step_s[WIDTH-1];
          end
        end
        default: begin
          if (start) begin
            if (multi_s) begin
              work_r  <= a;
              count_r <= amt_s;
              sh_op_r <= op[1:0];
            end else begin
              result_r <= imm_s;
              zero_r   <= (imm_s == {WIDTH{1'b0}});
              neg_r    <= imm_s[WIDTH-1];
            end
          end
        end
      endcase
    end
  end

  assign result = result_r;
  assign zero   = zero_r;
  assign neg    = neg_r;

endmodule
